// File: rtl/cdu_pkg.sv
// -----------------------------------------------------------------------------
// cdu_pkg
// Shared types and constants for the CDU coarse loop.
//   angle_t    : 16-bit angle, 2^16 LSB = 360 degrees
//   state_t    : coarse loop FSM state (TRACK / SLEW)
//   OCTANT_MSB : top bit of the 3-bit octant field in an angle
//   AMBIG_STEP : 180-degree correction applied on a confirmed ambiguity
//   OCTANT_SW  : octant -> active-low DC1..DC8 pattern (bit k-1 drives DCk)
// -----------------------------------------------------------------------------
package cdu_pkg;

    typedef logic [15:0] angle_t;

    typedef enum logic {
        TRACK = 1'b0,
        SLEW  = 1'b1
    } state_t;

    localparam int     OCTANT_MSB = 15;
    localparam angle_t AMBIG_STEP = 16'h8000;

    // One sin switch and one cos switch are pulled low per octant.
    //   o0: DC3,DC5  o1: DC4,DC6  o2: DC2,DC6  o3: DC1,DC5
    //   o4: DC1,DC7  o5: DC2,DC8  o6: DC4,DC8  o7: DC3,DC7
    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [7:0][7:0] OCTANT_SW = {
        8'hBB,  // o7
        8'h77,  // o6
        8'h7D,  // o5
        8'hBE,  // o4
        8'hEE,  // o3
        8'hDD,  // o2
        8'hD7,  // o1
        8'hEB   // o0
    };

    function automatic logic [7:0] octant_switches(input angle_t a);
        return OCTANT_SW[a[OCTANT_MSB -: 3]];
    endfunction

endpackage

// File: rtl/coarse_read_counter_if.sv
// -----------------------------------------------------------------------------
// coarse_read_counter_if
// Bundles the coarse loop signals between the CDU analog side / computer
// and the read counter.
//   Inputs to the counter : sample, _TLC1H, _ADHI, fine_up, fine_dn,
//                           slew_up, load, load_val
//   Outputs from counter  : count, _DC1.._DC12, cnt_up, cnt_dn, slewing,
//                           dbg_state
// Strobe semantics: sample, fine_up, fine_dn and load are single-cycle
// strobes sampled on the rising clk edge; there is no back-pressure, every
// strobe is consumed in the cycle it is presented. _TLC1H and _ADHI are only
// meaningful in a cycle where sample is high.
// -----------------------------------------------------------------------------
interface coarse_read_counter_if;
    import cdu_pkg::*;

    logic   sample;
    logic   _TLC1H;
    logic   _ADHI;
    logic   fine_up;
    logic   fine_dn;
    logic   slew_up;
    logic   load;
    angle_t load_val;

    angle_t count;
    logic   _DC1, _DC2, _DC3, _DC4, _DC5, _DC6;
    logic   _DC7, _DC8, _DC9, _DC10, _DC11, _DC12;
    logic   cnt_up;
    logic   cnt_dn;
    logic   slewing;
    state_t dbg_state;

    // Driver side (loop electronics / computer / testbench).
    modport master (
        output sample, _TLC1H, _ADHI, fine_up, fine_dn, slew_up, load, load_val,
        input  count, _DC1, _DC2, _DC3, _DC4, _DC5, _DC6,
               _DC7, _DC8, _DC9, _DC10, _DC11, _DC12,
               cnt_up, cnt_dn, slewing, dbg_state
    );

    // Counter side.
    modport slave (
        input  sample, _TLC1H, _ADHI, fine_up, fine_dn, slew_up, load, load_val,
        output count, _DC1, _DC2, _DC3, _DC4, _DC5, _DC6,
               _DC7, _DC8, _DC9, _DC10, _DC11, _DC12,
               cnt_up, cnt_dn, slewing, dbg_state
    );

endinterface

// File: rtl/coarse_switch_decode.sv
// -----------------------------------------------------------------------------
// coarse_switch_decode
// Registered decode of the read counter into the twelve active-low ladder
// switch drives. Output lags i_count by one clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_count    : current read counter
//   o_dc_n     : active-low drives, o_dc_n[k] drives _DCk (k = 1..12)
// -----------------------------------------------------------------------------
module coarse_switch_decode
    import cdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  angle_t      i_count,
    output logic [12:1] o_dc_n
);

    // Decode of count = 0: octant 0 pattern, DC9 low, DC10..DC12 high.
    localparam logic [12:1] DC_RESET = {1'b1, 1'b1, 1'b1, 1'b0, 8'hEB};

    logic [12:1] w_dc_n;
    logic [12:1] r_dc_n;

    // Reference switches: DC9 follows bit 12 directly, DC10..DC12 are the
    // complements of bits 11..9.
    always_comb begin
        w_dc_n = {~i_count[9], ~i_count[10], ~i_count[11], i_count[12],
                  octant_switches(i_count)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dc_n <= DC_RESET;
        end else begin
            r_dc_n <= w_dc_n;
        end
    end

    assign o_dc_n = r_dc_n;

endmodule

// File: rtl/coarse_read_counter.sv
// -----------------------------------------------------------------------------
// coarse_read_counter
// Digital side of the CDU coarse loop. Holds the 16-bit angle read counter,
// drives the coarse ladder switches from it, and closes the loop on the
// sampled threshold (_TLC1H) and ambiguity (_ADHI) signals. Fine-system
// count requests are merged in while tracking.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : coarse_read_counter_if.slave (see interface for signals)
// Parameters:
//   SLEW_DIV   : clk cycles between slew steps while slewing
//   SLEW_SHIFT : slew step is 2^SLEW_SHIFT LSB
//   CONFIRM    : consecutive asserted samples needed to slew / correct
// -----------------------------------------------------------------------------
module coarse_read_counter
    import cdu_pkg::*;
#(
    parameter int SLEW_DIV   = 16,
    parameter int SLEW_SHIFT = 6,
    parameter int CONFIRM    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    coarse_read_counter_if.slave  bus
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam int DW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

    localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SLEW_DIV - 1);
    localparam angle_t        SLEW_STEP = angle_t'(1) << SLEW_SHIFT;

    // Registered state
    state_t          r_state;
    logic [CW-1:0]   r_tl_cnt;
    logic [CW-1:0]   r_ad_cnt;
    logic [DW-1:0]   r_div;
    angle_t          r_count;
    logic            r_cnt_up;
    logic            r_cnt_dn;

    // Next-state values
    state_t          w_state_nxt;
    logic [CW-1:0]   w_tl_nxt;
    logic [CW-1:0]   w_ad_nxt;
    logic [DW-1:0]   w_div_nxt;
    angle_t          w_count_nxt;
    logic            w_cnt_up_nxt;
    logic            w_cnt_dn_nxt;

    // Decoded events
    logic [CW-1:0]   w_tl_inc;
    logic [CW-1:0]   w_ad_inc;
    logic            w_ad_fire;
    logic            w_slew_step;
    logic            w_fine_act;
    logic [12:1]     w_dc_n;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_tl_inc    = r_tl_cnt + CW'(1);
        w_ad_inc    = r_ad_cnt + CW'(1);
        w_ad_fire   = bus.sample && bus._ADHI && (w_ad_inc == CONFIRM_C);
        w_slew_step = (r_state == SLEW) && (r_div == DIV_LAST);
        // Opposing fine requests in the same cycle cancel out.
        w_fine_act  = (r_state == TRACK) && (bus.fine_up ^ bus.fine_dn);
    end

    // ------------------------------------------------------------------
    // FSM next state, confirm counters and slew divider
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tl_nxt    = r_tl_cnt;
        w_ad_nxt    = r_ad_cnt;
        w_div_nxt   = r_div;

        // Ambiguity confirm count runs in every state.
        if (bus.sample) begin
            if (bus._ADHI) begin
                w_ad_nxt = w_ad_fire ? '0 : w_ad_inc;
            end else begin
                w_ad_nxt = '0;
            end
        end

        case (r_state)
            TRACK: begin
                // Divider held clear so the first slew step lands a full
                // SLEW_DIV cycles after entering SLEW.
                w_div_nxt = '0;
                if (bus.sample) begin
                    if (bus._TLC1H) begin
                        w_tl_nxt = w_tl_inc;
                        if (w_tl_inc == CONFIRM_C) begin
                            w_state_nxt = SLEW;
                        end
                    end else begin
                        w_tl_nxt = '0;
                    end
                end
            end
            SLEW: begin
                w_div_nxt = w_slew_step ? '0 : r_div + DW'(1);
                if (bus.sample && !bus._TLC1H) begin
                    w_state_nxt = TRACK;
                    w_tl_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = TRACK;
                w_tl_nxt    = '0;
                w_div_nxt   = '0;
            end
        endcase

        // A confirmed ambiguity overrides whatever the threshold path chose.
        if (w_ad_fire) begin
            w_state_nxt = TRACK;
            w_tl_nxt    = '0;
            w_div_nxt   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Counter update: load > ambiguity > slew > fine. Only fine requests
    // produce tracking pulses; the computer is resynced separately for the
    // other update sources.
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt  = r_count;
        w_cnt_up_nxt = 1'b0;
        w_cnt_dn_nxt = 1'b0;

        if (bus.load) begin
            w_count_nxt = bus.load_val;
        end else if (w_ad_fire) begin
            w_count_nxt = r_count + AMBIG_STEP;
        end else if (w_slew_step) begin
            w_count_nxt = bus.slew_up ? (r_count + SLEW_STEP)
                                      : (r_count - SLEW_STEP);
        end else if (w_fine_act) begin
            w_count_nxt  = bus.fine_up ? (r_count + angle_t'(1))
                                       : (r_count - angle_t'(1));
            w_cnt_up_nxt = bus.fine_up;
            w_cnt_dn_nxt = bus.fine_dn;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= TRACK;
            r_tl_cnt <= '0;
            r_ad_cnt <= '0;
            r_div    <= '0;
            r_count  <= '0;
            r_cnt_up <= 1'b0;
            r_cnt_dn <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tl_cnt <= w_tl_nxt;
            r_ad_cnt <= w_ad_nxt;
            r_div    <= w_div_nxt;
            r_count  <= w_count_nxt;
            r_cnt_up <= w_cnt_up_nxt;
            r_cnt_dn <= w_cnt_dn_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Ladder switch decode
    // ------------------------------------------------------------------
    coarse_switch_decode u_decode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_count (r_count),
        .o_dc_n  (w_dc_n)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count     = r_count;
    assign bus.cnt_up    = r_cnt_up;
    assign bus.cnt_dn    = r_cnt_dn;
    assign bus.slewing   = (r_state == SLEW);
    assign bus.dbg_state = r_state;

    assign bus._DC1  = w_dc_n[1];
    assign bus._DC2  = w_dc_n[2];
    assign bus._DC3  = w_dc_n[3];
    assign bus._DC4  = w_dc_n[4];
    assign bus._DC5  = w_dc_n[5];
    assign bus._DC6  = w_dc_n[6];
    assign bus._DC7  = w_dc_n[7];
    assign bus._DC8  = w_dc_n[8];
    assign bus._DC9  = w_dc_n[9];
    assign bus._DC10 = w_dc_n[10];
    assign bus._DC11 = w_dc_n[11];
    assign bus._DC12 = w_dc_n[12];

endmodule

// File: tb/tb_coarse_read_counter.sv
// -----------------------------------------------------------------------------
// tb_coarse_read_counter
// Directed bench for coarse_read_counter: reset, fine tracking and wrap,
// ladder decode, slewing, ambiguity correction, update priority and
// asynchronous reset during a slew.
// -----------------------------------------------------------------------------
module tb_coarse_read_counter;
    import cdu_pkg::*;

    localparam int SLEW_DIV = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    coarse_read_counter_if bus ();

    coarse_read_counter #(
        .SLEW_DIV   (SLEW_DIV),
        .SLEW_SHIFT (6),
        .CONFIRM    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Inputs change and outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_count(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_count(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty expected queue, required one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.count, e);
        end
    endtask

    // Expected active-low drives, bit k-1 = _DCk.
    function automatic logic [11:0] dc_model(input logic [15:0] c);
        int          a;
        int          b;
        logic [11:0] v;
        case (c[15:13])
            3'd0:    begin a = 3; b = 5; end
            3'd1:    begin a = 4; b = 6; end
            3'd2:    begin a = 2; b = 6; end
            3'd3:    begin a = 1; b = 5; end
            3'd4:    begin a = 1; b = 7; end
            3'd5:    begin a = 2; b = 8; end
            3'd6:    begin a = 4; b = 8; end
            default: begin a = 3; b = 7; end
        endcase
        v        = '1;
        v[a-1]   = 1'b0;
        v[b-1]   = 1'b0;
        v[8]     = c[12];
        v[9]     = ~c[11];
        v[10]    = ~c[10];
        v[11]    = ~c[9];
        return v;
    endfunction

    function automatic logic [11:0] dc_obs();
        return {bus._DC12, bus._DC11, bus._DC10, bus._DC9, bus._DC8, bus._DC7,
                bus._DC6, bus._DC5, bus._DC4, bus._DC3, bus._DC2, bus._DC1};
    endfunction

    task automatic do_load(input logic [15:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic do_sample(input logic tlc, input logic adhi);
        bus.sample = 1'b1;
        bus._TLC1H = tlc;
        bus._ADHI  = adhi;
        step();
        bus.sample = 1'b0;
        bus._TLC1H = 1'b0;
        bus._ADHI  = 1'b0;
    endtask

    initial begin
        logic [15:0] v;

        bus.sample   = 1'b0;
        bus._TLC1H   = 1'b0;
        bus._ADHI    = 1'b0;
        bus.fine_up  = 1'b0;
        bus.fine_dn  = 1'b0;
        bus.slew_up  = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        expect_count(16'h0000);
        check_count("reset_count");
        check("reset_dc", {4'h0, dc_obs()}, 16'h0EEB);
        check("reset_slewing", {15'h0, bus.slewing}, 16'h0);
        check("reset_pulses", {14'h0, bus.cnt_up, bus.cnt_dn}, 16'h0);

        // ---------------- fine tracking and wrap ----------------
        do_load(16'hFFFF);
        expect_count(16'hFFFF);
        check_count("load_ffff");
        bus.fine_up = 1'b1;
        step();
        bus.fine_up = 1'b0;
        expect_count(16'h0000);
        check_count("fine_up_wrap");
        check("fine_up_pulse", {15'h0, bus.cnt_up}, 16'h1);
        step();
        check("fine_up_pulse_end", {15'h0, bus.cnt_up}, 16'h0);
        bus.fine_up = 1'b1;
        bus.fine_dn = 1'b1;
        step();
        bus.fine_up = 1'b0;
        bus.fine_dn = 1'b0;
        expect_count(16'h0000);
        check_count("fine_cancel");
        check("fine_cancel_pulse", {14'h0, bus.cnt_up, bus.cnt_dn}, 16'h0);
        bus.fine_dn = 1'b1;
        step();
        bus.fine_dn = 1'b0;
        expect_count(16'hFFFF);
        check_count("fine_dn_wrap");
        check("fine_dn_pulse", {14'h0, bus.cnt_up, bus.cnt_dn}, 16'h1);

        // ---------------- decode sweep ----------------
        for (int k = 1; k < 8; k++) begin
            v = 16'(k) << 13;
            do_load(v);
            step();
            check($sformatf("decode_oct%0d", k), {4'h0, dc_obs()}, {4'h0, dc_model(v)});
        end
        do_load(16'h1E00);
        step();
        check("decode_ref", {4'h0, dc_obs()}, {4'h0, dc_model(16'h1E00)});
        check("decode_ref_bits", {12'h0, bus._DC12, bus._DC11, bus._DC10, bus._DC9}, 16'h1);

        // ---------------- slew ----------------
        do_load(16'h0000);
        bus.slew_up = 1'b1;
        do_sample(1'b1, 1'b0);
        check("slew_one_sample", {15'h0, bus.slewing}, 16'h0);
        step();
        do_sample(1'b1, 1'b0);
        check("slew_enter", {15'h0, bus.slewing}, 16'h1);
        for (int i = 1; i <= 3 * SLEW_DIV; i++) begin
            bus.fine_up = (i == 3);
            step();
            bus.fine_up = 1'b0;
            if (i == 3) begin
                expect_count(16'h0000);
                check_count("slew_fine_ignored");
                check("slew_fine_no_pulse", {15'h0, bus.cnt_up}, 16'h0);
            end
            if (i == 3 * SLEW_DIV - 1) begin
                expect_count(16'h0080);
                check_count("slew_two_steps");
            end
        end
        expect_count(16'h00C0);
        check_count("slew_three_steps");
        do_sample(1'b0, 1'b0);
        check("slew_exit", {15'h0, bus.slewing}, 16'h0);
        expect_count(16'h00C0);
        check_count("slew_exit_count");

        // ---------------- ambiguity ----------------
        do_load(16'h1234);
        do_sample(1'b0, 1'b1);
        expect_count(16'h1234);
        check_count("ambig_one_sample");
        step();
        do_sample(1'b0, 1'b1);
        expect_count(16'h9234);
        check_count("ambig_correct");
        do_sample(1'b0, 1'b1);
        steps(2);
        expect_count(16'h9234);
        check_count("ambig_no_reapply");

        // ---------------- priority ----------------
        bus.slew_up = 1'b1;
        do_sample(1'b1, 1'b0);
        do_sample(1'b1, 1'b0);
        check("prio_slewing", {15'h0, bus.slewing}, 16'h1);
        steps(SLEW_DIV - 1);
        bus.load     = 1'b1;
        bus.load_val = 16'h4000;
        bus.fine_up  = 1'b1;
        step();
        bus.load     = 1'b0;
        bus.fine_up  = 1'b0;
        expect_count(16'h4000);
        check_count("prio_load_wins");
        check("prio_no_pulse", {14'h0, bus.cnt_up, bus.cnt_dn}, 16'h0);
        check("prio_stay_slew", {15'h0, bus.slewing}, 16'h1);

        // ---------------- reset mid-slew ----------------
        steps(3);
        rst_n = 1'b0;
        #1;
        expect_count(16'h0000);
        check_count("reset_mid_slew_count");
        check("reset_mid_slew_slewing", {15'h0, bus.slewing}, 16'h0);
        check("reset_mid_slew_dc", {4'h0, dc_obs()}, 16'h0EEB);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- threshold and ambiguity together ----------------
        do_load(16'h0100);
        do_sample(1'b1, 1'b1);
        do_sample(1'b1, 1'b1);
        expect_count(16'h8100);
        check_count("both_ambig_wins");
        check("both_stay_track", {15'h0, bus.slewing}, 16'h0);
        do_sample(1'b1, 1'b0);
        check("both_tl_cleared", {15'h0, bus.slewing}, 16'h0);
        do_sample(1'b1, 1'b0);
        check("both_tl_reconfirm", {15'h0, bus.slewing}, 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
